mem_port_arbiter: RTL and testbench

Single-clock arbiter that shares the processor's unified single-port word memory between three requesters: debug/program loader, data access (LW/SW from the MEM stage), and instruction fetch (IF stage). Sits between the pipeline and the memory array, replacing direct array access. Grants at most one access per cycle and routes read data back to the owner one cycle later. A starvation counter keeps fetch from being locked out by back-to-back data traffic.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_pick3.sv | 22 ++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: owner tags, FSM states, defaults.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

  // Who is waiting for the read data that the memory returns next cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_DBG   = 2'd1,
    OWN_DMEM  = 2'd2,
    OWN_FETCH = 2'd3
  } owner_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_PEND = 1'b1
  } arb_state_e;

  // True when at least two of the three requesters compete in the same cycle.
  function automatic logic two_or_more(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick3.sv
// Combinational 3-way fixed-priority picker (hi > mid > lo), lo can be promoted over mid.
// Latency: 0 cycles, pure combinational.
// Backpressure: losers simply see no grant and keep requesting.
// Ports: i_req_hi/mid/lo requests, i_promote_lo lifts lo above mid (never above hi),
//        o_gnt_hi/mid/lo one-hot (or zero) grants.
module fixed_prio_pick3 (
  input  logic i_req_hi,
  input  logic i_req_mid,
  input  logic i_req_lo,
  input  logic i_promote_lo,
  output logic o_gnt_hi,
  output logic o_gnt_mid,
  output logic o_gnt_lo
);

  always_comb begin
    o_gnt_hi  = i_req_hi;
    o_gnt_mid = i_req_mid & ~i_req_hi & ~(i_req_lo & i_promote_lo);
    o_gnt_lo  = i_req_lo  & ~i_req_hi & (~i_req_mid | i_promote_lo);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between loader (dbg), data (dmem) and fetch ports.
// Latency: grant same cycle as request, read data one cycle after grant, one access per cycle.
// Backpressure: losing requesters get no gnt and must hold their request; fetch is promoted
//   above dmem after STARVE_LIMIT consecutive denied cycles.
// Ports: dbg_*/dmem_*/fetch_* requester sides (req/gnt/rvalid/rdata), mem_* memory strobe
//   side, conflict_cnt saturating count of cycles with two or more requests.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dmem_req,
  input  logic          dmem_we,
  input  logic [AW-1:0] dmem_addr,
  input  logic [DW-1:0] dmem_wdata,
  output logic          dmem_gnt,
  output logic          dmem_rvalid,
  output logic [DW-1:0] dmem_rdata,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [DW-1:0] fetch_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   conflict_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e    r_state, w_state_nxt;
  owner_e        r_owner, w_owner_nxt;
  logic [SW-1:0] r_starve_cnt, w_starve_nxt;
  logic [15:0]   r_conflict_cnt;
  logic [DW-1:0] r_dbg_rdata, r_dmem_rdata, r_fetch_rdata;

  logic w_promote;
  logic w_gnt_dbg, w_gnt_dmem, w_gnt_fetch;

  assign w_promote = (r_starve_cnt == STARVE_MAX);

  // Requests are masked during reset so no grant or memory strobe escapes.
  fixed_prio_pick3 u_pick (
    .i_req_hi     (dbg_req   & ~rst),
    .i_req_mid    (dmem_req  & ~rst),
    .i_req_lo     (fetch_req & ~rst),
    .i_promote_lo (w_promote),
    .o_gnt_hi     (w_gnt_dbg),
    .o_gnt_mid    (w_gnt_dmem),
    .o_gnt_lo     (w_gnt_fetch)
  );

  // ---------------- state register ----------------
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_NONE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // ---------------- next state ----------------
  // Both states accept a new grant every cycle; the state only records whether a read
  // is in flight and for whom, so IDLE and RD_PEND share the same transition rule.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_gnt_dbg && !dbg_we) begin
      w_owner_nxt = OWN_DBG;
    end else if (w_gnt_dmem && !dmem_we) begin
      w_owner_nxt = OWN_DMEM;
    end else if (w_gnt_fetch) begin
      w_owner_nxt = OWN_FETCH;
    end

    w_state_nxt = (w_owner_nxt == OWN_NONE) ? ST_IDLE : ST_RD_PEND;

    // Counts consecutive denied fetch cycles; stays saturated while dbg keeps winning.
    w_starve_nxt = '0;
    if (fetch_req && !w_gnt_fetch) begin
      w_starve_nxt = w_promote ? STARVE_MAX : (r_starve_cnt + SW'(1));
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    dbg_gnt   = w_gnt_dbg;
    dmem_gnt  = w_gnt_dmem;
    fetch_gnt = w_gnt_fetch;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_dbg) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (w_gnt_dmem) begin
      mem_en    = 1'b1;
      mem_we    = dmem_we;
      mem_addr  = dmem_addr;
      mem_wdata = dmem_wdata;
    end else if (w_gnt_fetch) begin
      mem_en    = 1'b1;
      mem_addr  = fetch_addr;
    end

    dbg_rvalid   = ~rst && (r_state == ST_RD_PEND) && (r_owner == OWN_DBG);
    dmem_rvalid  = ~rst && (r_state == ST_RD_PEND) && (r_owner == OWN_DMEM);
    fetch_rvalid = ~rst && (r_state == ST_RD_PEND) && (r_owner == OWN_FETCH);

    // The memory delivers data in the rvalid cycle; pass it through then and hold it after.
    dbg_rdata   = rst ? '0 : (dbg_rvalid   ? mem_rdata : r_dbg_rdata);
    dmem_rdata  = rst ? '0 : (dmem_rvalid  ? mem_rdata : r_dmem_rdata);
    fetch_rdata = rst ? '0 : (fetch_rvalid ? mem_rdata : r_fetch_rdata);

    conflict_cnt = r_conflict_cnt;
  end

  // ---------------- return-data hold registers ----------------
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_dbg_rdata   <= '0;
      r_dmem_rdata  <= '0;
      r_fetch_rdata <= '0;
    end else begin
      if (dbg_rvalid)   r_dbg_rdata   <= mem_rdata;
      if (dmem_rvalid)  r_dmem_rdata  <= mem_rdata;
      if (fetch_rvalid) r_fetch_rdata <= mem_rdata;
    end
  end

  // ---------------- contention counter ----------------
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (two_or_more(dbg_req, dmem_req, fetch_req) && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk1;
  logic        rst;
  logic        dbg_req, dbg_we;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        dmem_req, dmem_we;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        fetch_req;
  logic [9:0]  fetch_addr;
  logic        fetch_gnt, fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] conflict_cnt;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.AW(10), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk1(clk1), .rst(rst),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // Single-port word memory; contents preloaded while reset is high.
  always @(posedge clk1) begin
    if (rst) begin
      mem[0]   <= 32'h280a00c8;
      mem[1]   <= 32'h10000001;
      mem[2]   <= 32'h10000002;
      mem[3]   <= 32'h10000003;
      mem[4]   <= 32'h10000004;
      mem[200] <= 32'd5;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk1);
    #1;
  endtask

  task automatic sample();
    @(negedge clk1);
  endtask

  task automatic idle_inputs();
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    dmem_req = 0; dmem_we = 0; dmem_addr = '0; dmem_wdata = '0;
    fetch_req = 0; fetch_addr = '0;
  endtask

  logic [31:0] fetch_exp [0:4];
  logic [5:0]  starve_f_exp;
  logic [5:0]  starve_d_exp;

  initial begin
    fetch_exp[0] = 32'h280a00c8;
    fetch_exp[1] = 32'h10000001;
    fetch_exp[2] = 32'h10000002;
    fetch_exp[3] = 32'h10000003;
    fetch_exp[4] = 32'h10000004;
    starve_f_exp = 6'b010000;   // bit i = fetch_gnt in cycle i
    starve_d_exp = 6'b101111;

    // ---- reset: a fetch request is held during reset and must be ignored ----
    rst = 1;
    idle_inputs();
    fetch_req = 1;
    sample();
    check("rst_fetch_gnt", fetch_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rvalid", {dbg_rvalid, dmem_rvalid, fetch_rvalid}, 0);
    check("rst_rdata", {dbg_rdata, dmem_rdata, fetch_rdata}, 0);
    next_cycle();
    check("rst_conflict", conflict_cnt, 0);

    // ---- release with no requests: idle ----
    rst = 0;
    idle_inputs();
    sample();
    check("idle_gnt", {dbg_gnt, dmem_gnt, fetch_gnt}, 0);
    check("idle_mem_en", mem_en, 0);

    // ---- fetch-only stream, addr 0..4 ----
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      fetch_req = 1; fetch_addr = 10'(i);
      sample();
      check($sformatf("fetch_gnt_%0d", i), fetch_gnt, 1);
      check($sformatf("fetch_addr_%0d", i), mem_addr, i);
      if (i > 0) begin
        check($sformatf("fetch_rvalid_%0d", i), fetch_rvalid, 1);
        check($sformatf("fetch_rdata_%0d", i), fetch_rdata, fetch_exp[i-1]);
      end
    end
    next_cycle();
    idle_inputs();
    sample();
    check("fetch_rvalid_last", fetch_rvalid, 1);
    check("fetch_rdata_last", fetch_rdata, 32'h10000004);
    next_cycle();
    sample();
    check("fetch_rvalid_drop", fetch_rvalid, 0);
    check("fetch_rdata_hold", fetch_rdata, 32'h10000004);
    check("conflict_after_fetch", conflict_cnt, 0);

    // ---- dmem read vs fetch in the same cycle ----
    next_cycle();
    dmem_req = 1; dmem_addr = 10'd200; fetch_req = 1; fetch_addr = 10'd5;
    sample();
    check("dm_vs_f_dmem_gnt", dmem_gnt, 1);
    check("dm_vs_f_fetch_gnt", fetch_gnt, 0);
    check("dm_vs_f_addr", mem_addr, 200);
    next_cycle();
    idle_inputs();
    sample();
    check("dm_rvalid", dmem_rvalid, 1);
    check("dm_rdata", dmem_rdata, 5);
    check("dm_fetch_rvalid", fetch_rvalid, 0);
    check("dm_conflict", conflict_cnt, 1);

    // ---- starvation promotion: 6 cycles dmem + fetch ----
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      dmem_req = 1; dmem_addr = 10'd200; fetch_req = 1; fetch_addr = 10'd1;
      sample();
      check($sformatf("starve_fetch_gnt_%0d", i), fetch_gnt, starve_f_exp[i]);
      check($sformatf("starve_dmem_gnt_%0d", i), dmem_gnt, starve_d_exp[i]);
    end
    next_cycle();
    idle_inputs();
    sample();
    check("starve_conflict", conflict_cnt, 7);
    check("starve_last_dmem_rvalid", dmem_rvalid, 1);

    // ---- dbg write beats both, no read return ----
    next_cycle();
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'd198; dbg_wdata = 32'hDEADBEEF;
    dmem_req = 1; dmem_addr = 10'd200; fetch_req = 1; fetch_addr = 10'd1;
    sample();
    check("dbgw_gnt", {dbg_gnt, dmem_gnt, fetch_gnt}, 3'b100);
    check("dbgw_mem_we", mem_we, 1);
    check("dbgw_mem_addr", mem_addr, 198);
    check("dbgw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    next_cycle();
    idle_inputs();
    dmem_req = 1; dmem_addr = 10'd198;
    sample();
    check("dbgw_no_rvalid", {dbg_rvalid, dmem_rvalid, fetch_rvalid}, 0);
    check("rd198_gnt", dmem_gnt, 1);
    next_cycle();
    idle_inputs();
    dbg_req = 1; dbg_addr = 10'd198;
    sample();
    check("rd198_rvalid", dmem_rvalid, 1);
    check("rd198_rdata", dmem_rdata, 32'hDEADBEEF);
    check("dbgw_conflict", conflict_cnt, 8);
    next_cycle();
    idle_inputs();
    sample();
    check("dbgr_rvalid", {dbg_rvalid, dmem_rvalid, fetch_rvalid}, 3'b100);
    check("dbgr_rdata", dbg_rdata, 32'hDEADBEEF);

    // ---- reset right after a granted fetch read ----
    next_cycle();
    fetch_req = 1; fetch_addr = 10'd0;
    sample();
    check("pre_rst_fetch_gnt", fetch_gnt, 1);
    next_cycle();
    idle_inputs();
    rst = 1;
    sample();
    check("rst_suppress_rvalid", fetch_rvalid, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    next_cycle();
    rst = 0;
    sample();
    check("post_rst_rvalid", {dbg_rvalid, dmem_rvalid, fetch_rvalid}, 0);
    check("post_rst_rdata", {dbg_rdata, dmem_rdata, fetch_rdata}, 0);
    check("post_rst_conflict", conflict_cnt, 0);
    check("post_rst_gnt", {dbg_gnt, dmem_gnt, fetch_gnt}, 0);

    // ---- long contention: counter saturation ----
    next_cycle();
    dmem_req = 1; dmem_addr = 10'd200; fetch_req = 1; fetch_addr = 10'd0;
    sample();
    check("sat_first_dmem_gnt", dmem_gnt, 1);
    check("sat_first_fetch_gnt", fetch_gnt, 0);
    for (int i = 0; i < 70000; i++) @(posedge clk1);
    sample();
    check("conflict_saturated", conflict_cnt, 16'hFFFF);
    next_cycle();
    idle_inputs();
    sample();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
